// File: rtl/lcd_bus_arbiter_if.sv
// Bus bundle between the two LCD clients, the arbiter and the shared transfer engine.
// The master modport is the arbiter's view; the slave modport is the clients/engine view.
interface lcd_bus_arbiter_if #(
   parameter int unsigned CNT_W = 2
);
   logic             req_a, req_b;
   logic             lock_a, lock_b;
   logic [CNT_W-1:0] cnt_a, cnt_b;
   logic             mode_a, mode_b;
   logic             rs_a, rs_b;
   logic             dsel_a, dsel_b;
   logic             dbsel_a, dbsel_b;
   logic             gnt_a, gnt_b;
   logic             done_a, done_b;
   logic             lcd_enable;
   logic [CNT_W-1:0] lcd_cnt;
   logic             mode, reg_sel, data_sel, DB_sel;
   logic             lcd_finish;
   logic             err_timeout;

   modport master (
      input  req_a, req_b, lock_a, lock_b, cnt_a, cnt_b, mode_a, mode_b,
             rs_a, rs_b, dsel_a, dsel_b, dbsel_a, dbsel_b, lcd_finish,
      output gnt_a, gnt_b, done_a, done_b, lcd_enable, lcd_cnt,
             mode, reg_sel, data_sel, DB_sel, err_timeout
   );

   modport slave (
      output req_a, req_b, lock_a, lock_b, cnt_a, cnt_b, mode_a, mode_b,
             rs_a, rs_b, dsel_a, dsel_b, dbsel_a, dbsel_b, lcd_finish,
      input  gnt_a, gnt_b, done_a, done_b, lcd_enable, lcd_cnt,
             mode, reg_sel, data_sel, DB_sel, err_timeout
   );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter sharing one LCD transfer engine between a refresh sequencer (A)
// and a status writer (B), with ownership lock and a finish watchdog.
module lcd_bus_arbiter #(
   parameter int unsigned CNT_W      = 2,
   parameter int unsigned TIMEOUT_MS = 50
) (
   input  logic        clk_1ms,
   input  logic        reset_n,
   lcd_bus_arbiter_if.master bus
);
   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

   localparam logic [7:0] TMAX = 8'(TIMEOUT_MS - 1);

   state_t           state_q, state_d;
   logic             owner_q, owner_d;   // 0 = A, 1 = B
   logic             last_q, last_d;
   logic             lock_q, lock_d;
   logic             abort_q, abort_d;
   logic [7:0]       timer_q, timer_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mode_q, mode_d;
   logic             rs_q, rs_d;
   logic             dsel_q, dsel_d;
   logic             dbsel_q, dbsel_d;
   logic             grant_a, grant_b;

   always_ff @(posedge clk_1ms or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         lock_q  <= 1'b0;
         abort_q <= 1'b0;
         timer_q <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b1;
         rs_q    <= 1'b0;
         dsel_q  <= 1'b0;
         dbsel_q <= 1'b1;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         lock_q  <= lock_d;
         abort_q <= abort_d;
         timer_q <= timer_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         rs_q    <= rs_d;
         dsel_q  <= dsel_d;
         dbsel_q <= dbsel_d;
      end
   end

   // With a lock held, last_q names the lock owner.
   always_comb begin
      grant_a = bus.req_a && (lock_q ? !last_q : (!bus.req_b || last_q));
      grant_b = bus.req_b && (lock_q ?  last_q : (!bus.req_a || !last_q));
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      lock_d  = lock_q;
      abort_d = abort_q;
      timer_d = timer_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      rs_d    = rs_q;
      dsel_d  = dsel_q;
      dbsel_d = dbsel_q;
      case (state_q)
         S_IDLE: begin
            if (grant_a) begin
               owner_d = 1'b0;
               abort_d = 1'b0;
               cnt_d   = bus.cnt_a;
               mode_d  = bus.mode_a;
               rs_d    = bus.rs_a;
               dsel_d  = bus.dsel_a;
               dbsel_d = bus.dbsel_a;
               state_d = S_LAUNCH;
            end else if (grant_b) begin
               owner_d = 1'b1;
               abort_d = 1'b0;
               cnt_d   = bus.cnt_b;
               mode_d  = bus.mode_b;
               rs_d    = bus.rs_b;
               dsel_d  = bus.dsel_b;
               dbsel_d = bus.dbsel_b;
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.lcd_finish) begin
               state_d = S_DONE;
            end else if (timer_q == TMAX) begin
               abort_d = 1'b1;
               state_d = S_DONE;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         S_DONE: begin
            last_d  = owner_q;
            lock_d  = !abort_q && (owner_q ? bus.lock_b : bus.lock_a);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.gnt_a       = (state_q != S_IDLE) && !owner_q;
      bus.gnt_b       = (state_q != S_IDLE) &&  owner_q;
      bus.done_a      = (state_q == S_DONE) && !owner_q;
      bus.done_b      = (state_q == S_DONE) &&  owner_q;
      bus.lcd_enable  = (state_q == S_LAUNCH);
      bus.err_timeout = (state_q == S_DONE) && abort_q;
      bus.lcd_cnt     = cnt_q;
      bus.mode        = mode_q;
      bus.reg_sel     = rs_q;
      bus.data_sel    = dsel_q;
      bus.DB_sel      = dbsel_q;
   end
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: transaction-level model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_lcd_bus_arbiter;
   localparam int unsigned CW = 2;
   localparam int unsigned TO = 50;

   logic clk_1ms = 1'b0;
   logic reset_n = 1'b0;

   lcd_bus_arbiter_if #(.CNT_W(CW)) bus ();

   lcd_bus_arbiter #(.CNT_W(CW), .TIMEOUT_MS(TO)) dut (
      .clk_1ms (clk_1ms),
      .reset_n (reset_n),
      .bus     (bus.master)
   );

   always #5 clk_1ms = ~clk_1ms;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model: who owns the engine, which phase of the transfer it is in, and arbitration memory.
   int       m_own;
   bit       m_launch, m_wait, m_done, m_abort, m_lock;
   int       m_last, m_waited, pick;
   bit [1:0] m_cnt;
   bit       m_mode, m_rs, m_ds, m_db;

   initial begin
      forever begin
         @(posedge clk_1ms or negedge reset_n);
         if (!reset_n) begin
            m_own = -1; m_launch = 0; m_wait = 0; m_done = 0; m_abort = 0;
            m_lock = 0; m_last = 1; m_waited = 0;
            m_cnt = 0; m_mode = 1; m_rs = 0; m_ds = 0; m_db = 1;
         end else if (m_done) begin
            m_last = m_own;
            m_lock = !m_abort && ((m_own == 0) ? bus.lock_a : bus.lock_b);
            m_done = 0;
            m_own  = -1;
         end else if (m_launch) begin
            m_launch = 0; m_wait = 1; m_waited = 0;
         end else if (m_wait) begin
            if (bus.lcd_finish) begin
               m_wait = 0; m_done = 1; m_abort = 0;
            end else begin
               m_waited++;
               if (m_waited == int'(TO)) begin
                  m_wait = 0; m_done = 1; m_abort = 1;
               end
            end
         end else begin
            pick = -1;
            if (m_lock) begin
               if (m_last == 0 && bus.req_a) pick = 0;
               else if (m_last == 1 && bus.req_b) pick = 1;
            end else if (bus.req_a && bus.req_b) pick = 1 - m_last;
            else if (bus.req_a) pick = 0;
            else if (bus.req_b) pick = 1;
            if (pick == 0) begin
               m_cnt = bus.cnt_a; m_mode = bus.mode_a; m_rs = bus.rs_a;
               m_ds = bus.dsel_a; m_db = bus.dbsel_a;
            end else if (pick == 1) begin
               m_cnt = bus.cnt_b; m_mode = bus.mode_b; m_rs = bus.rs_b;
               m_ds = bus.dsel_b; m_db = bus.dbsel_b;
            end
            if (pick >= 0) begin
               m_own = pick; m_launch = 1;
            end
         end
      end
   end

   logic [11:0] exp_v, act_v;
   initial begin
      forever begin
         @(posedge clk_1ms);
         #1;
         exp_v = {m_own == 0, m_own == 1, m_done && m_own == 0, m_done && m_own == 1,
                  m_launch, m_done && m_abort, m_cnt, m_mode, m_rs, m_ds, m_db};
         act_v = {bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.lcd_enable,
                  bus.err_timeout, bus.lcd_cnt, bus.mode, bus.reg_sel, bus.data_sel, bus.DB_sel};
         n_tests++;
         if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL cycle_model @%0t: got %b expected %b", $time, act_v, exp_v);
         end
      end
   end

   task automatic wait_launch(input string name, input int bound, output int who);
      who = -1;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk_1ms);
         if (bus.lcd_enable) begin
            who = bus.gnt_a ? 0 : (bus.gnt_b ? 1 : 2);
            break;
         end
      end
      if (who < 0) begin
         n_tests++; n_fail++;
         $display("FAIL %s: no launch within %0d cycles", name, bound);
      end
   endtask

   task automatic wait_done(input string name, input int bound, output int cyc);
      cyc = -1;
      for (int i = 1; i <= bound; i++) begin
         @(negedge clk_1ms);
         if (bus.done_a || bus.done_b) begin
            cyc = i;
            break;
         end
      end
      if (cyc < 0) begin
         n_tests++; n_fail++;
         $display("FAIL %s: no done within %0d cycles", name, bound);
      end
   endtask

   task automatic reset_begin();
      @(negedge clk_1ms);
      reset_n = 1'b0;
      bus.req_a = 0; bus.req_b = 0; bus.lock_a = 0; bus.lock_b = 0;
      bus.cnt_a = '0; bus.cnt_b = '0; bus.mode_a = 1; bus.mode_b = 1;
      bus.rs_a = 0; bus.rs_b = 0; bus.dsel_a = 0; bus.dsel_b = 0;
      bus.dbsel_a = 1; bus.dbsel_b = 1; bus.lcd_finish = 0;
      repeat (2) @(negedge clk_1ms);
   endtask

   task automatic reset_end();
      reset_n = 1'b1;
   endtask

   int who, cyc, en_cnt;
   int order[4];

   initial begin
      // 1: single A transfer, finish 5 cycles after launch
      reset_begin();
      chk("rst_gnt_a", int'(bus.gnt_a), 0);
      chk("rst_mode", int'(bus.mode), 1);
      chk("rst_db_sel", int'(bus.DB_sel), 1);
      chk("rst_cnt", int'(bus.lcd_cnt), 0);
      reset_end();
      bus.cnt_a = 2'd3; bus.mode_a = 0; bus.rs_a = 1; bus.dsel_a = 1; bus.dbsel_a = 0;
      bus.req_a = 1;
      wait_launch("t1_launch", 10, who);
      chk("t1_owner", who, 0);
      chk("t1_cnt", int'(bus.lcd_cnt), 3);
      chk("t1_mode", int'(bus.mode), 0);
      chk("t1_reg_sel", int'(bus.reg_sel), 1);
      chk("t1_data_sel", int'(bus.data_sel), 1);
      chk("t1_db_sel", int'(bus.DB_sel), 0);
      @(negedge clk_1ms);
      chk("t1_en_pulse", int'(bus.lcd_enable), 0);
      chk("t1_gnt_wait", int'(bus.gnt_a), 1);
      repeat (3) @(negedge clk_1ms);
      bus.lcd_finish = 1;
      wait_done("t1_done", 10, cyc);
      chk("t1_latency", cyc, 1);
      chk("t1_done_a", int'(bus.done_a), 1);
      chk("t1_gnt_done", int'(bus.gnt_a), 1);
      bus.req_a = 0; bus.lcd_finish = 0;
      @(negedge clk_1ms);
      chk("t1_gnt_off", int'(bus.gnt_a), 0);
      chk("t1_done_off", int'(bus.done_a), 0);

      // 2: both requesting from reset alternate A,B,A,B
      reset_begin();
      bus.req_a = 1; bus.req_b = 1; bus.lcd_finish = 1;
      reset_end();
      for (int k = 0; k < 4; k++) wait_launch("t2_launch", 10, order[k]);
      bus.req_a = 0; bus.req_b = 0;
      wait_done("t2_done", 10, cyc);
      bus.lcd_finish = 0;
      chk("t2_order0", order[0], 0);
      chk("t2_order1", order[1], 1);
      chk("t2_order2", order[2], 0);
      chk("t2_order3", order[3], 1);

      // 3: lock keeps A over B for one extra transfer
      reset_begin();
      bus.lock_a = 1; bus.req_a = 1; bus.req_b = 1; bus.lcd_finish = 1;
      reset_end();
      wait_launch("t3_l1", 10, order[0]);
      wait_launch("t3_l2", 10, order[1]);
      bus.lock_a = 0;
      wait_launch("t3_l3", 10, order[2]);
      bus.req_a = 0; bus.req_b = 0;
      wait_done("t3_done", 10, cyc);
      bus.lcd_finish = 0;
      chk("t3_first", order[0], 0);
      chk("t3_locked", order[1], 0);
      chk("t3_unlocked", order[2], 1);

      // 4: watchdog abort after TO wait cycles clears the lock
      reset_begin();
      reset_end();
      bus.req_a = 1; bus.lock_a = 1;
      wait_launch("t4_launch", 10, who);
      wait_done("t4_done", 80, cyc);
      chk("t4_abort_lat", cyc, 51);
      chk("t4_err", int'(bus.err_timeout), 1);
      chk("t4_done_a", int'(bus.done_a), 1);
      bus.req_a = 0; bus.req_b = 1;
      wait_launch("t4_b_after", 10, who);
      chk("t4_b_owner", who, 1);
      chk("t4_err_off", int'(bus.err_timeout), 0);
      bus.lock_a = 0; bus.lcd_finish = 1;
      wait_done("t4_b_done", 10, cyc);
      bus.req_b = 0; bus.lcd_finish = 0;

      // 5: reset during WAIT, then pending B granted
      reset_begin();
      reset_end();
      bus.cnt_b = 2'd2; bus.mode_b = 0; bus.rs_b = 1; bus.dsel_b = 1; bus.dbsel_b = 0;
      bus.req_b = 1;
      wait_launch("t5_launch", 10, who);
      chk("t5_owner", who, 1);
      repeat (3) @(negedge clk_1ms);
      reset_n = 0;
      #1;
      chk("t5_rst_gnt", int'(bus.gnt_b), 0);
      chk("t5_rst_cnt", int'(bus.lcd_cnt), 0);
      chk("t5_rst_mode", int'(bus.mode), 1);
      chk("t5_rst_dbsel", int'(bus.DB_sel), 1);
      chk("t5_rst_done", int'(bus.done_b), 0);
      @(negedge clk_1ms);
      reset_n = 1;
      wait_launch("t5_relaunch", 10, who);
      chk("t5_re_owner", who, 1);
      chk("t5_re_cnt", int'(bus.lcd_cnt), 2);
      bus.lcd_finish = 1;
      wait_done("t5_done", 10, cyc);
      bus.req_b = 0; bus.lcd_finish = 0;

      // 6: req_a dropped mid-transfer still completes, no relaunch
      reset_begin();
      reset_end();
      bus.req_a = 1;
      wait_launch("t6_launch", 10, who);
      repeat (2) @(negedge clk_1ms);
      bus.req_a = 0;
      repeat (2) @(negedge clk_1ms);
      bus.lcd_finish = 1;
      wait_done("t6_done", 10, cyc);
      chk("t6_done_a", int'(bus.done_a), 1);
      bus.lcd_finish = 0;
      en_cnt = 0;
      repeat (6) begin
         @(negedge clk_1ms);
         if (bus.lcd_enable) en_cnt++;
      end
      chk("t6_no_relaunch", en_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end
endmodule
